debug_scan_sequencer: RTL
=========================

# debug_scan_sequencer

Controller that drives the SNN debug multiplexer's configuration port to scan every observable signal in a fixed order. Per frame it steps through the 16 membrane-potential slices, then layer-1 spikes, then layer-2 spikes. For each slot it captures the multiplexed 8-bit debug value and presents it on a valid/ready stream tagged with the slot index. It sits between the host/debug port logic and the debug multiplexer, and supports single-frame, continuous periodic, and manual single-write modes.

## Interface
Parameters:
- `DW`, 8: debug data width.
- `PERIOD_W`, 16: width of the inter-frame gap counter.
- `SETTLE`, 0: extra wait cycles between config load and capture.

Ports:
- `clk`  in  1: system clock, all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a frame when IDLE; ignored when busy.
- `continuous`  in  1: sampled at frame end; 1 = schedule next frame after `period`.
- `period`  in  PERIOD_W: idle cycles between frames in continuous mode.
- `host_cfg`  in  8: manual debug selection code.
- `host_cfg_wr`  in  1: one-cycle manual write of `host_cfg`; honoured only in IDLE.
- `cfg_out`  out  8: configuration code to the debug multiplexer.
- `cfg_en`  out  1: load enable to the debug multiplexer's config register.
- `debug_in`  in  DW: multiplexed debug value returned by the debug multiplexer.
- `out_data`  out  DW: captured sample.
- `out_tag`  out  5: slot index 0..17 of `out_data`.
- `out_valid`  out  1: sample available.
- `out_ready`  in  1: consumer accepts the sample.
- `busy`  out  1: high in any state other than IDLE.
- `frame_done`  out  1: one-cycle pulse after the slot-17 transfer.

## Operation
- Slot-to-code map:
  - slots 0..15 → code = slot;
  - slot 16 → 8'h1F (layer-1 spikes);
  - slot 17 → 8'h20 (layer-2 spikes, the multiplexer's default arm).
- FSM states: IDLE, LOAD, SETTLE, CAPTURE, PRESENT, GAP.
- IDLE:
  - `start` → LOAD with slot = 0.
  - `host_cfg_wr` (with `start` low) → `cfg_out` = `host_cfg`, `cfg_en` = 1 for one cycle; stay in IDLE.
  - If `start` and `host_cfg_wr` are both high, `start` wins and the write is dropped.
- LOAD:
  - `cfg_out` = map(slot), `cfg_en` = 1.
  - Next state is SETTLE if `SETTLE` > 0, otherwise CAPTURE.
- SETTLE: counts `SETTLE` cycles, then goes to CAPTURE.
- CAPTURE: at the closing edge, latch `out_data` ← `debug_in`, `out_tag` ← slot, `out_valid` ← 1; go to PRESENT.
- PRESENT:
  - Hold `out_data` and `out_tag` stable while `out_valid & !out_ready`.
  - On `out_valid & out_ready`, clear `out_valid`.
  - If slot < 17: slot++ and go to LOAD.
  - If slot = 17: pulse `frame_done`, then go to GAP if `continuous`=1, otherwise IDLE.
- GAP:
  - A down-counter is loaded with `period`; when it reaches 0, go to LOAD with slot = 0.
  - `period` = 0 gives one GAP cycle.
  - `continuous` deasserted during GAP → IDLE on the next cycle.
- `cfg_en` is 0 in every state other than LOAD and a manual IDLE write.
- `cfg_out` holds its last driven value when `cfg_en` = 0.

## Timing
- Reset values: `cfg_out`=0, `cfg_en`=0, `out_data`=0, `out_tag`=0, `out_valid`=0, `busy`=0, `frame_done`=0. FSM in IDLE, slot=0, gap counter=0.
- Reset mid-frame: all outputs return to reset values immediately; no partial frame completes.
- The debug multiplexer registers its config on the edge closing LOAD. `debug_in` is valid in the following cycle, which is when CAPTURE samples it.
- Per-slot latency with `SETTLE`=0 and `out_ready` held high is 3 cycles: LOAD, CAPTURE, PRESENT.
- A full frame takes 54 cycles from the first LOAD to the `frame_done` cycle. With `SETTLE`=S, it takes 18·(3+S) cycles.
- `out_valid` rises on the edge closing CAPTURE.
- Backpressure stalls PRESENT indefinitely with no data loss. `cfg_out` does not change while stalled.
- `start` pulses during `busy` are dropped; they are not queued.

## Structure
- Package `debug_seq_pkg` holds:
  - state enum;
  - `NUM_SLOTS`=18;
  - `CFG_SPK_L1`=8'h1F and `CFG_SPK_L2`=8'h20;
  - function `slot_to_cfg(slot)`.
- One sub-module, `debug_period_timer`: the loadable GAP/SETTLE down-counter with a zero flag.

## Test plan
- Reset, then `start` with `out_ready`=1 and `debug_in` driven by a behavioural mux model. Expect 18 transfers with tags 0..17, `cfg_out` sequence 0..15, 0x1F, 0x20, and `frame_done` exactly 54 cycles after the first LOAD.
- Hold `out_ready`=0 for 10 cycles at slot 5. Expect `out_data`, `out_tag`=5 and `cfg_out`=5 stable throughout, and no LOAD until the transfer completes.
- Set `continuous`=1, `period`=4. Expect slot-0 LOAD on cycle 5 after `frame_done`; clear `continuous` and expect IDLE after the current frame or gap.
- In IDLE, pulse `host_cfg_wr` with `host_cfg`=8'h1F. Expect one cycle of `cfg_en`=1 with `cfg_out`=0x1F, and `busy` staying 0. The same pulse while busy has no effect.
- Deassert `rst_n` at slot 9 with `out_valid`=1. Expect all outputs at reset values asynchronously; a subsequent `start` begins cleanly at slot 0.
- Set `SETTLE`=2. Expect 90-cycle frames, and capture of `debug_in` exactly 3 cycles after each `cfg_en`.

Source files
------------

// File: rtl/debug_scan_sequencer_pkg.sv
// Shared types and constants for the debug scan sequencer: FSM states,
// slot count and the slot-to-mux-code map.
package debug_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CAPTURE,
    ST_PRESENT,
    ST_GAP
  } state_t;

  localparam int NUM_SLOTS = 18;
  localparam int SLOT_W    = 5;

  localparam logic [7:0] CFG_SPK_L1 = 8'h1F;
  localparam logic [7:0] CFG_SPK_L2 = 8'h20;

  // Slots 0..15 select membrane slices directly; 16 and 17 pick the spike arms.
  function automatic logic [7:0] slot_to_cfg(input logic [SLOT_W-1:0] slot);
    if (slot < 5'd16)
      return {3'b000, slot};
    else if (slot == 5'd16)
      return CFG_SPK_L1;
    else
      return CFG_SPK_L2;
  endfunction

endpackage

// File: rtl/debug_period_timer.sv
// Loadable down-counter with a zero flag, shared by the settle wait and the
// inter-frame gap.
module debug_period_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/debug_scan_sequencer.sv
// Walks the debug multiplexer through all 18 observable slots per frame and
// streams each captured value out with its slot tag.
module debug_scan_sequencer
  import debug_seq_pkg::*;
#(
  parameter int DW       = 8,
  parameter int PERIOD_W = 16,
  parameter int SETTLE   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          host_cfg,
  input  logic                host_cfg_wr,
  output logic [7:0]          cfg_out,
  output logic                cfg_en,
  input  logic [DW-1:0]       debug_in,
  output logic [DW-1:0]       out_data,
  output logic [4:0]          out_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [PERIOD_W-1:0] SETTLE_LD = (SETTLE > 0) ? PERIOD_W'(SETTLE - 1) : '0;
  localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  state_t              state;
  logic [SLOT_W-1:0]   slot;
  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;
  logic [PERIOD_W-1:0] tmr_val;

  debug_period_timer #(
    .W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Settle loads SETTLE-1 so the SETTLE state lasts exactly SETTLE cycles;
  // the gap loads period so period=0 still spends one cycle in GAP.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = SETTLE_LD;
    unique case (state)
      ST_LOAD:           tmr_load = (SETTLE > 0);
      ST_SETTLE, ST_GAP: tmr_dec  = 1'b1;
      ST_PRESENT: begin
        if (out_ready && (slot == LAST_SLOT) && continuous) begin
          tmr_load = 1'b1;
          tmr_val  = period;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      slot       <= '0;
      cfg_out    <= '0;
      cfg_en     <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cfg_en     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            slot    <= '0;
            cfg_out <= slot_to_cfg(5'd0);
            cfg_en  <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end else if (host_cfg_wr) begin
            cfg_out <= host_cfg;
            cfg_en  <= 1'b1;
          end
        end
        ST_LOAD:
          state <= (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;
        ST_SETTLE:
          if (tmr_zero) state <= ST_CAPTURE;
        // Mux output reflects the config loaded at the end of LOAD.
        ST_CAPTURE: begin
          out_data  <= debug_in;
          out_tag   <= slot;
          out_valid <= 1'b1;
          state     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (slot != LAST_SLOT) begin
              slot    <= slot + 1'b1;
              cfg_out <= slot_to_cfg(slot + 1'b1);
              cfg_en  <= 1'b1;
              state   <= ST_LOAD;
            end else begin
              frame_done <= 1'b1;
              if (continuous) begin
                state <= ST_GAP;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          if (!continuous) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (tmr_zero) begin
            slot    <= '0;
            cfg_out <= slot_to_cfg(5'd0);
            cfg_en  <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
